// File: rtl/usb_tx_packet_buffer_if.sv
// usb_tx_packet_buffer_if: sample-input and slave-FIFO-output handshakes of the packet buffer.
interface usb_tx_packet_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 10
);
  logic [DATA_WIDTH-1:0] iData;
  logic [DATA_WIDTH-1:0] oUsbTxData;
  logic iDataValid;
  logic oDataReady;
  logic iFlush;
  logic oUsbTxValid;
  logic iUsbTxReady;
  logic oUsbTxPktEnd;
  logic [DEPTH_LOG2:0] oFifoLevel;
  modport master(
    output iData, iDataValid, iFlush, iUsbTxReady,
    input oDataReady, oUsbTxData, oUsbTxValid, oUsbTxPktEnd, oFifoLevel
  );
  modport slave(
    input iData, iDataValid, iFlush, iUsbTxReady,
    output oDataReady, oUsbTxData, oUsbTxValid, oUsbTxPktEnd, oFifoLevel
  );
endinterface

// File: rtl/usb_tx_packet_buffer.sv
// usb_tx_packet_buffer: circular sample buffer releasing full or flushed short bulk-IN packets.
module usb_tx_packet_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int PKT_WORDS = 256
) (
  input logic iClk,
  input logic iReset,
  usb_tx_packet_buffer_if.slave bus
);
  localparam int AW = DEPTH_LOG2 + 1;
  localparam logic [AW-1:0] PKT_LEN = AW'(PKT_WORDS);
  localparam logic [AW-1:0] CAPACITY = AW'(2 ** DEPTH_LOG2);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] mem [2 ** DEPTH_LOG2];
  logic [AW-1:0] wrPtr, rdPtr, level, cnt;
  logic isShort, flushPending, txValid, txPktEnd, wrEn, rdEn;
  assign level = wrPtr - rdPtr;
  assign bus.oFifoLevel = level;
  assign bus.oDataReady = level != CAPACITY && !iReset;
  assign bus.oUsbTxValid = txValid;
  assign bus.oUsbTxPktEnd = txPktEnd;
  assign bus.oUsbTxData = mem[rdPtr[DEPTH_LOG2-1:0]];
  assign wrEn = bus.iDataValid && bus.oDataReady;
  assign rdEn = txValid && bus.iUsbTxReady;
  always_ff @(posedge iClk)
    if (wrEn) mem[wrPtr[DEPTH_LOG2-1:0]] <= bus.iData;
  always_ff @(posedge iClk)
    if (iReset) begin
      state <= IDLE;
      wrPtr <= '0;
      rdPtr <= '0;
      cnt <= '0;
      isShort <= 1'b0;
      flushPending <= 1'b0;
      txValid <= 1'b0;
      txPktEnd <= 1'b0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      flushPending <= flushPending || bus.iFlush;
      if (state == IDLE) begin
        // full packets win, so a pending flush waits for the remainder
        if (level >= PKT_LEN) begin
          state <= SEND;
          txValid <= 1'b1;
          cnt <= PKT_LEN;
          isShort <= 1'b0;
          txPktEnd <= 1'b0;
        end else if (flushPending) begin
          flushPending <= bus.iFlush;
          if (level != '0) begin
            state <= SEND;
            txValid <= 1'b1;
            cnt <= level;
            isShort <= 1'b1;
            txPktEnd <= level == AW'(1);
          end
        end
      end else if (rdEn) begin
        rdPtr <= rdPtr + 1'b1;
        cnt <= cnt - 1'b1;
        txPktEnd <= isShort && cnt == AW'(2);
        if (cnt == AW'(1)) begin
          state <= IDLE;
          txValid <= 1'b0;
          txPktEnd <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_usb_tx_packet_buffer.sv
// tb_usb_tx_packet_buffer: directed scenario tests of the USB TX packet buffer.
module tb_usb_tx_packet_buffer;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  logic [15:0] wrData;
  int wrLeft = 0;
  always #5 clk = ~clk;
  usb_tx_packet_buffer_if #(.DATA_WIDTH(16), .DEPTH_LOG2(10)) bus ();
  usb_tx_packet_buffer #(.DATA_WIDTH(16), .DEPTH_LOG2(10), .PKT_WORDS(256)) dut (
    .iClk(clk),
    .iReset(rst),
    .bus(bus)
  );
  task automatic load(input logic [15:0] base, input int n);
    wrData = base;
    wrLeft = n;
    bus.iData = base;
    bus.iDataValid = n > 0;
  endtask
  task automatic tick(output bit v, output bit got, output logic [15:0] d, output bit pe);
    bit wAcc;
    v = bus.oUsbTxValid;
    got = v && bus.iUsbTxReady;
    d = bus.oUsbTxData;
    pe = bus.oUsbTxPktEnd;
    wAcc = bus.iDataValid && bus.oDataReady;
    @(posedge clk);
    #1;
    if (wAcc) begin
      wrData++;
      wrLeft--;
    end
    bus.iDataValid = wrLeft > 0;
    bus.iData = wrData;
  endtask
  task automatic test_reset();
    bit v, got, pe;
    logic [15:0] d;
    rst = 1'b1;
    tick(v, got, d, pe);
    tick(v, got, d, pe);
    checks++;
    if (bus.oDataReady !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.oDataReady); end
    checks++;
    if (bus.oUsbTxValid !== 1'b0 || bus.oUsbTxPktEnd !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b/%b exp=0/0", bus.oUsbTxValid, bus.oUsbTxPktEnd); end
    checks++;
    if (bus.oFifoLevel !== 11'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.oFifoLevel); end
    rst = 1'b0;
    tick(v, got, d, pe);
    checks++;
    if (bus.oDataReady !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", bus.oDataReady); end
  endtask
  task automatic test_full_packet();
    bit v, got, pe;
    logic [15:0] d;
    int rx = 0;
    int badPe = 0;
    bus.iUsbTxReady = 1'b1;
    load(16'h0000, 256);
    for (int c = 0; c < 700 && rx < 256; c++) begin
      tick(v, got, d, pe);
      if (got) begin
        checks++;
        if (d !== 16'(rx)) begin failures++; $display("FAIL full_data[%0d] got=%h exp=%h", rx, d, 16'(rx)); end
        if (pe) badPe++;
        rx++;
      end
    end
    checks++;
    if (rx != 256) begin failures++; $display("FAIL full_count got=%0d exp=256", rx); end
    checks++;
    if (badPe != 0) begin failures++; $display("FAIL full_pktend got=%0d exp=0", badPe); end
    tick(v, got, d, pe);
    checks++;
    if (bus.oFifoLevel !== 11'd0 || bus.oUsbTxValid !== 1'b0) begin failures++; $display("FAIL full_drain level=%0d valid=%b exp=0/0", bus.oFifoLevel, bus.oUsbTxValid); end
  endtask
  task automatic test_short_packet();
    bit v, got, pe;
    logic [15:0] d;
    int rx = 0;
    int early = 0;
    bus.iUsbTxReady = 1'b1;
    load(16'hA000, 10);
    for (int c = 0; c < 14; c++) begin
      tick(v, got, d, pe);
      if (v) early++;
    end
    checks++;
    if (early != 0 || bus.oFifoLevel !== 11'd10) begin failures++; $display("FAIL short_prefill valid_cycles=%0d level=%0d exp=0/10", early, bus.oFifoLevel); end
    bus.iFlush = 1'b1;
    tick(v, got, d, pe);
    bus.iFlush = 1'b0;
    checks++;
    if (bus.oUsbTxValid !== 1'b0) begin failures++; $display("FAIL short_latency1 got=%b exp=0", bus.oUsbTxValid); end
    tick(v, got, d, pe);
    checks++;
    if (bus.oUsbTxValid !== 1'b1) begin failures++; $display("FAIL short_latency2 got=%b exp=1", bus.oUsbTxValid); end
    for (int c = 0; c < 40 && rx < 10; c++) begin
      tick(v, got, d, pe);
      if (got) begin
        checks++;
        if (d !== 16'hA000 + 16'(rx) || pe !== (rx == 9)) begin failures++; $display("FAIL short_word[%0d] got=%h/%b exp=%h/%b", rx, d, pe, 16'hA000 + 16'(rx), rx == 9); end
        rx++;
      end
    end
    checks++;
    if (rx != 10) begin failures++; $display("FAIL short_count got=%0d exp=10", rx); end
    load(16'hA100, 1);
    early = 0;
    for (int c = 0; c < 12; c++) begin
      tick(v, got, d, pe);
      if (v) early++;
    end
    checks++;
    if (early != 0 || bus.oFifoLevel !== 11'd1) begin failures++; $display("FAIL short_flush_cleared valid_cycles=%0d level=%0d exp=0/1", early, bus.oFifoLevel); end
    bus.iFlush = 1'b1;
    tick(v, got, d, pe);
    bus.iFlush = 1'b0;
    tick(v, got, d, pe);
    checks++;
    if (bus.oUsbTxValid !== 1'b1 || bus.oUsbTxPktEnd !== 1'b1 || bus.oUsbTxData !== 16'hA100) begin failures++; $display("FAIL short_single got=%b/%b/%h exp=1/1/a100", bus.oUsbTxValid, bus.oUsbTxPktEnd, bus.oUsbTxData); end
    tick(v, got, d, pe);
    tick(v, got, d, pe);
    checks++;
    if (bus.oFifoLevel !== 11'd0 || bus.oUsbTxValid !== 1'b0) begin failures++; $display("FAIL short_drain level=%0d valid=%b exp=0/0", bus.oFifoLevel, bus.oUsbTxValid); end
  endtask
  task automatic test_flush_empty();
    bit v, got, pe;
    logic [15:0] d;
    int rx = 0;
    int seen = 0;
    int badPe = 0;
    bus.iUsbTxReady = 1'b1;
    bus.iFlush = 1'b1;
    tick(v, got, d, pe);
    bus.iFlush = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick(v, got, d, pe);
      if (v) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL empty_flush valid_cycles=%0d exp=0", seen); end
    load(16'h1000, 256);
    for (int c = 0; c < 700 && rx < 256; c++) begin
      tick(v, got, d, pe);
      if (got) begin
        checks++;
        if (d !== 16'h1000 + 16'(rx)) begin failures++; $display("FAIL empty_full_data[%0d] got=%h exp=%h", rx, d, 16'h1000 + 16'(rx)); end
        if (pe) badPe++;
        rx++;
      end
    end
    checks++;
    if (rx != 256 || badPe != 0) begin failures++; $display("FAIL empty_full_count got=%0d/%0d exp=256/0", rx, badPe); end
  endtask
  task automatic test_back_to_back();
    bit v, got, pe;
    bit prevV = 1'b1;
    bit flushed = 1'b0;
    logic [15:0] d;
    int rx = 0;
    int rises = 0;
    bus.iUsbTxReady = 1'b0;
    load(16'h2000, 1030);
    for (int c = 0; c < 1100; c++) tick(v, got, d, pe);
    checks++;
    if (wrLeft != 6) begin failures++; $display("FAIL b2b_accepted got=%0d exp=1024", 1030 - wrLeft); end
    checks++;
    if (bus.oFifoLevel !== 11'd1024 || bus.oDataReady !== 1'b0) begin failures++; $display("FAIL b2b_full level=%0d ready=%b exp=1024/0", bus.oFifoLevel, bus.oDataReady); end
    bus.iUsbTxReady = 1'b1;
    tick(v, got, d, pe);
    checks++;
    if (!got || d !== 16'h2000) begin failures++; $display("FAIL b2b_first got=%b/%h exp=1/2000", got, d); end
    rx = 1;
    checks++;
    if (bus.oDataReady !== 1'b1 || bus.oFifoLevel !== 11'd1023) begin failures++; $display("FAIL b2b_free_slot ready=%b level=%0d exp=1/1023", bus.oDataReady, bus.oFifoLevel); end
    for (int c = 0; c < 3000 && rx < 1030; c++) begin
      bus.iFlush = wrLeft == 0 && !flushed;
      if (bus.iFlush) flushed = 1'b1;
      tick(v, got, d, pe);
      bus.iFlush = 1'b0;
      if (v && !prevV) rises++;
      prevV = v;
      if (got) begin
        checks++;
        if (d !== 16'h2000 + 16'(rx) || pe !== (rx == 1029)) begin failures++; $display("FAIL b2b_word[%0d] got=%h/%b exp=%h/%b", rx, d, pe, 16'h2000 + 16'(rx), rx == 1029); end
        rx++;
      end
    end
    checks++;
    if (rx != 1030) begin failures++; $display("FAIL b2b_count got=%0d exp=1030", rx); end
    checks++;
    if (rises != 4) begin failures++; $display("FAIL b2b_packets got=%0d exp=4", rises); end
    tick(v, got, d, pe);
    checks++;
    if (bus.oFifoLevel !== 11'd0 || bus.oUsbTxValid !== 1'b0) begin failures++; $display("FAIL b2b_drain level=%0d valid=%b exp=0/0", bus.oFifoLevel, bus.oUsbTxValid); end
  endtask
  task automatic test_backpressure();
    bit v, got, pe;
    bit prevV = 1'b0;
    bit prevRdy = 1'b0;
    bit prevPe = 1'b0;
    logic [15:0] d;
    logic [15:0] prevD = '0;
    logic [31:0] pat = 32'hB4E1_96A3;
    int rx = 0;
    int badHold = 0;
    load(16'h3000, 256);
    for (int c = 0; c < 2000 && rx < 256; c++) begin
      bus.iUsbTxReady = pat[c % 32];
      tick(v, got, d, pe);
      if (prevV && !prevRdy && (!v || d !== prevD || pe !== prevPe)) badHold++;
      prevV = v;
      prevRdy = got;
      prevD = d;
      prevPe = pe;
      if (got) begin
        checks++;
        if (d !== 16'h3000 + 16'(rx) || pe !== 1'b0) begin failures++; $display("FAIL bp_word[%0d] got=%h/%b exp=%h/0", rx, d, pe, 16'h3000 + 16'(rx)); end
        rx++;
      end
    end
    checks++;
    if (rx != 256) begin failures++; $display("FAIL bp_count got=%0d exp=256", rx); end
    checks++;
    if (badHold != 0) begin failures++; $display("FAIL bp_hold unstable_cycles=%0d exp=0", badHold); end
  endtask
  task automatic test_reset_mid_packet();
    bit v, got, pe;
    logic [15:0] d;
    int rx = 0;
    bus.iUsbTxReady = 1'b1;
    load(16'h4000, 256);
    for (int c = 0; c < 700 && rx < 100; c++) begin
      tick(v, got, d, pe);
      if (got) rx++;
    end
    checks++;
    if (rx != 100 || bus.oUsbTxValid !== 1'b1) begin failures++; $display("FAIL mid_progress got=%0d/%b exp=100/1", rx, bus.oUsbTxValid); end
    wrLeft = 0;
    bus.iDataValid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.oDataReady !== 1'b0) begin failures++; $display("FAIL mid_ready_in_reset got=%b exp=0", bus.oDataReady); end
    tick(v, got, d, pe);
    checks++;
    if (bus.oUsbTxValid !== 1'b0 || bus.oFifoLevel !== 11'd0) begin failures++; $display("FAIL mid_abandon valid=%b level=%0d exp=0/0", bus.oUsbTxValid, bus.oFifoLevel); end
    rst = 1'b0;
    tick(v, got, d, pe);
    checks++;
    if (bus.oDataReady !== 1'b1 || bus.oUsbTxValid !== 1'b0 || bus.oFifoLevel !== 11'd0) begin failures++; $display("FAIL mid_recover ready=%b valid=%b level=%0d exp=1/0/0", bus.oDataReady, bus.oUsbTxValid, bus.oFifoLevel); end
  endtask
  initial begin
    rst = 1'b1;
    bus.iData = '0;
    bus.iDataValid = 1'b0;
    bus.iFlush = 1'b0;
    bus.iUsbTxReady = 1'b0;
    test_reset();
    test_full_packet();
    test_short_packet();
    test_flush_empty();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/usb_tx_packet_buffer.md
# usb_tx_packet_buffer

Upstream stage of the FX2 (CY7C68013A) slave-FIFO interface. Accepts a 16-bit sample stream from the simulation core, buffers it in a circular RAM and releases it in bulk-IN packets. Full packets are exactly PKT_WORDS words; on flush, a short packet is released with an end-of-packet marker. The downstream slave-FIFO writer drives USB_FD/SLWR from this block's output and turns the marker into PKTEND.

## Interface
Parameters:
- DATA_WIDTH, 16, word width; matches the 16-bit FD bus.
- DEPTH_LOG2, 10, log2 of buffer depth (1024 words).
- PKT_WORDS, 256, words per full packet (512-byte bulk packet). Must be ≤ 2^DEPTH_LOG2.

Ports:
- iClk  in  1  sole clock. Reset is synchronous and active-high.
- iReset  in  1  synchronous, active-high reset.
- iData  in  DATA_WIDTH  input sample word.
- iDataValid  in  1  iData valid.
- oDataReady  out  1  buffer can accept a word.
- iFlush  in  1  single-cycle request to release buffered data as a short packet.
- oUsbTxData  out  DATA_WIDTH  word to the slave-FIFO writer.
- oUsbTxValid  out  1  oUsbTxData valid.
- iUsbTxReady  in  1  writer accepts the word this cycle.
- oUsbTxPktEnd  out  1  current word is the last word of a short packet.
- oFifoLevel  out  DEPTH_LOG2+1  number of words stored.

## Operation
- Storage: 2^DEPTH_LOG2 × DATA_WIDTH RAM with asynchronous read (distributed).
- Pointers: write and read pointers are each DEPTH_LOG2+1 bits and wrap naturally.
- Level and status: level = wr_ptr − rd_ptr, modulo 2^(DEPTH_LOG2+1). full = (level == 2^DEPTH_LOG2).
- Write side:
  - oDataReady = !full && !iReset.
  - A write occurs when iDataValid && oDataReady. The word is stored at wr_ptr and wr_ptr increments.
  - A source holding iDataValid while not ready must keep iData stable.
- Flush latch: iFlush sets flush_pending. It stays set until cleared by the read FSM.
- Read FSM, two states:
  - IDLE:
    - If level ≥ PKT_WORDS: load cnt = PKT_WORDS, short = 0, go to SEND.
    - Else if flush_pending and level > 0: load cnt = level, short = 1, clear flush_pending, go to SEND.
    - Else if flush_pending and level == 0: clear flush_pending and stay in IDLE. No zero-length packet is produced.
    - The full-packet rule has priority, so flush_pending survives across full packets until the remainder is sent.
  - SEND:
    - oUsbTxValid = 1 and oUsbTxData = mem[rd_ptr].
    - oUsbTxPktEnd = short && (cnt == 1).
    - On oUsbTxValid && iUsbTxReady: rd_ptr increments and cnt decrements.
    - When the word with cnt == 1 is accepted, go to IDLE.
- Short-packet length is fixed at the IDLE decision. Words written afterwards wait for the next packet.
- An iFlush arriving during SEND only sets flush_pending. It is evaluated at the next IDLE.

## Timing
- Reset values: state IDLE, pointers 0, flush_pending 0, oUsbTxValid 0, oUsbTxPktEnd 0, oFifoLevel 0, oDataReady 0 during reset and 1 the cycle after.
- Reset mid-packet: the packet is abandoned and buffered data is discarded. oUsbTxValid is 0 in the cycle after iReset is sampled high.
- oFifoLevel is registered, derived from registered pointers. It reflects a write or read one cycle after the handshake. A simultaneous write and read leaves level unchanged.
- Packet start latency: with a level of PKT_WORDS visible at cycle N, oUsbTxValid first rises at N+1.
- Flush latency: iFlush at cycle N sets flush_pending at N+1. SEND starts at N+2 if IDLE and level > 0.
- Packet gap: at least one IDLE cycle between consecutive packets. oUsbTxValid is low for ≥1 cycle.
- Hold under backpressure: while oUsbTxValid && !iUsbTxReady, oUsbTxData and oUsbTxPktEnd are held stable.
- Full boundary: with level == 2^DEPTH_LOG2, a read in cycle N frees one slot. oDataReady rises at N+1.
- Flush on the same cycle as the final write: that word is included in the short packet.

## Test plan
- Full packet: write words 0..255 with iUsbTxReady = 1 → one 256-word packet 0..255 in order; oUsbTxPktEnd never asserts; oFifoLevel returns to 0.
- Short packet: write 10 words 0xA000..0xA009, then pulse iFlush → 10-word packet; oUsbTxPktEnd is high only on 0xA009; flush_pending is cleared.
- Flush while empty: pulse iFlush with level 0 → no oUsbTxValid for 20 cycles; a later 256-word write still produces one full packet.
- Full buffer with mixed packets:
  - Stimulus: iUsbTxReady = 0, write 1030 words.
  - Required: oDataReady drops after word 1023 and oFifoLevel = 1024.
  - Stimulus: set iUsbTxReady = 1, write the remaining 6 words, then pulse iFlush.
  - Required: four full packets, then a 6-word short packet with pktend on the last word.
- Backpressure: toggle iUsbTxReady pseudo-randomly during a 256-word packet → no duplicated or skipped words; data is stable while stalled.
- Reset mid-packet: assert iReset after 100 words of a packet are accepted → oUsbTxValid is 0 the next cycle, oFifoLevel is 0, oDataReady is 1 one cycle after reset is released.
